// File: rtl/mont_s_update.sv
// ----------------------------------------------------------------------------
// mont_s_update
//   Word-serial Montgomery (CIOS) inner-loop stage. For each outer iteration
//   it latches x_i and the Q' factor q_m, then streams Y[j]/M[j] from the
//   operand memory. It computes S = (S + x*Y + q*M) / 2^16 one 16-bit word per
//   step. S (NWORDS+1 words) is held internally and accumulates across
//   iterations until cleared. The new low word S[0] is exported
//   registered so that the Q' generator can form the next factor.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   start      in   begin one iteration (sampled in IDLE only)
//   clr        in   synchronous clear of all S words (IDLE only, beats start)
//   x_i        in   current X word, latched on the start edge
//   q_m        in   Q' adjustment factor, latched on the start edge
//   mem_rd     out  operand read strobe
//   mem_addr   out  operand word index j
//   y_word     in   Y[j], valid one cycle after mem_rd
//   m_word     in   M[j], valid one cycle after mem_rd
//   busy       out  high from the start edge until DONE is left
//   done       out  single-cycle completion pulse
//   low_err    out  sticky: word-0 low half of the sum was nonzero
//   s0_out     out  S[0], registered at completion
//   s_rd_addr  in   result word select, 0..NWORDS
//   s_rd_data  out  S[s_rd_addr], combinational, 0 when out of range
// ----------------------------------------------------------------------------
module mont_s_update #(
   parameter int NWORDS = 2,
   parameter int AW     = 6,
   parameter int SAW    = 7
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            clr,
   input  logic [15:0]     x_i,
   input  logic [15:0]     q_m,
   output logic            mem_rd,
   output logic [AW-1:0]   mem_addr,
   input  logic [15:0]     y_word,
   input  logic [15:0]     m_word,
   output logic            busy,
   output logic            done,
   output logic            low_err,
   output logic [15:0]     s0_out,
   input  logic [SAW-1:0]  s_rd_addr,
   output logic [15:0]     s_rd_data
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CALC = 3'd2,
      TOP  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t        state_q, state_d;

   logic [15:0]   s_q [0:NWORDS];
   logic [AW-1:0] j_q;
   logic [17:0]   carry_q;
   logic [15:0]   x_q;
   logic [15:0]   q_q;

   logic          last_j;
   logic [15:0]   s_j;
   logic [31:0]   prod_y;
   logic [31:0]   prod_m;
   logic [33:0]   t;
   logic [18:0]   u;

   assign last_j   = (j_q == AW'(NWORDS - 1));
   assign mem_rd   = (state_q == RD);
   assign mem_addr = j_q;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   // NOTE: every clocked block uses non-blocking (<=) assignments so all
   // flops sample their inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic; clr has priority over start in IDLE, and both are
   // ignored in every other state.
   // ---------------------------------------------------------------------
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!clr && start) state_d = RD;
         RD:      state_d = CALC;
         CALC:    state_d = last_j ? TOP : RD;
         TOP:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Word-step arithmetic. Both products are full 32-bit. The 34-bit sum
   // holds S[j] + two products + an 18-bit carry without overflow.
   // ---------------------------------------------------------------------
   always_comb begin
      s_j = '0;
      for (int k = 0; k < NWORDS; k++) begin
         if (j_q == AW'(k)) s_j = s_q[k];
      end
   end

   assign prod_y = {16'h0000, x_q} * {16'h0000, y_word};
   assign prod_m = {16'h0000, q_q} * {16'h0000, m_word};
   assign t      = {18'h0, s_j} + {2'b00, prod_y} + {2'b00, prod_m} + {16'h0, carry_q};

   // Final fold of the carry into the top word.
   assign u      = {3'b000, s_q[NWORDS]} + {1'b0, carry_q};

   // Result read port; out-of-range addresses read as zero.
   always_comb begin
      s_rd_data = '0;
      for (int k = 0; k <= NWORDS; k++) begin
         if (s_rd_addr == SAW'(k)) s_rd_data = s_q[k];
      end
   end

   // ---------------------------------------------------------------------
   // Datapath and registered outputs
   // ---------------------------------------------------------------------
   // NOTE: the S register file is built from flops and is cleared by reset,
   // so a reset mid-iteration leaves no partial result; it must not be
   // mapped to a RAM macro.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k <= NWORDS; k++) s_q[k] <= '0;
         j_q     <= '0;
         carry_q <= '0;
         x_q     <= '0;
         q_q     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         low_err <= 1'b0;
         s0_out  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (clr) begin
                  for (int k = 0; k <= NWORDS; k++) s_q[k] <= '0;
               end else if (start) begin
                  x_q     <= x_i;
                  q_q     <= q_m;
                  j_q     <= '0;
                  carry_q <= '0;
                  low_err <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            CALC: begin
               // Word 0 of the sum is shifted out; q_m was chosen to make it
               // zero, so a nonzero value flags a bad factor upstream.
               if (j_q == '0) begin
                  if (t[15:0] != 16'h0000) low_err <= 1'b1;
               end else begin
                  for (int k = 0; k < NWORDS - 1; k++) begin
                     if (j_q == AW'(k + 1)) s_q[k] <= t[15:0];
                  end
               end
               carry_q <= t[33:16];
               if (!last_j) j_q <= j_q + 1'b1;
            end
            TOP: begin
               s_q[NWORDS-1] <= u[15:0];
               s_q[NWORDS]   <= {13'h0000, u[18:16]};
            end
            DONE: begin
               done   <= 1'b1;
               s0_out <= s_q[0];
               busy   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mont_s_update.md
Name: mont_s_update

Overview:
- Word-serial Montgomery (CIOS) inner-loop stage, directly downstream of the Q' generator.
- Per outer iteration it consumes x_i and the adjustment factor q_m, then streams Y[j] and M[j] from the operand memory.
- Computes S = (S + x_i*Y + q_m*M) / 2^16 one 16-bit word per step and holds S in an internal register file.
- Exposes the new low word S[0] so the Q' generator can compute the next iteration's factor.

Parameters:
- NWORDS, 2, number of 16-bit words in Y and M (legal 2..64).
- AW, 6, operand memory address width; must satisfy 2^AW >= NWORDS.
- SAW, 7, S read-port address width; must satisfy 2^SAW >= NWORDS+1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin one iteration; sampled only in IDLE.
- clr  in  1  synchronous clear of all S words; honoured only in IDLE.
- x_i  in  16  current X word; latched on the start edge.
- q_m  in  16  Q' adjustment factor; latched on the start edge.
- mem_rd  out  1  operand read strobe.
- mem_addr  out  AW  operand word index j.
- y_word  in  16  Y[j], valid exactly 1 cycle after mem_rd.
- m_word  in  16  M[j], valid exactly 1 cycle after mem_rd.
- busy  out  1  high from the start edge until DONE is left.
- done  out  1  single-cycle completion pulse.
- low_err  out  1  sticky flag: word-0 low half was nonzero.
- s0_out  out  16  S[0], registered.
- s_rd_addr  in  SAW  result word select, 0..NWORDS.
- s_rd_data  out  16  S[s_rd_addr], combinational; 0 when out of range.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State goes to IDLE; all S words, j, carry, latched x/q cleared.
  - busy, done, mem_rd, low_err = 0; mem_addr = 0; s0_out = 0.
  - Reset mid-iteration abandons the iteration with no partial result kept.
- State register is one of IDLE, RD, CALC, TOP, DONE.
- IDLE:
  - clr=1: all S words := 0; start is ignored that cycle (clr wins).
  - Otherwise start=1: latch x_i and q_m, j := 0, carry := 0, low_err := 0, busy := 1, go to RD.
- RD:
  - mem_rd = 1 and mem_addr = j for one cycle, then go to CALC.
  - mem_rd is 0 in every other state.
- CALC:
  - t(34b) = S[j] + x*y_word + q*m_word + carry(18b).
  - j = 0: t[15:0] is discarded; if it is nonzero, low_err := 1.
  - j >= 1: S[j-1] := t[15:0].
  - carry := t[33:16] for all j.
  - If j = NWORDS-1, go to TOP; else j := j+1 and go to RD.
- TOP:
  - u = S[NWORDS] + carry.
  - S[NWORDS-1] := u[15:0]; S[NWORDS] := u >> 16 (zero-extended).
  - Go to DONE.
- DONE:
  - done = 1 for one cycle; s0_out updated from S[0]; busy := 0 on exit; go to IDLE.
- Latency: done is high on the cycle 2*NWORDS+2 clocks after the start-sampling edge.
- Back-to-back iterations allowed: start may be asserted in the first IDLE cycle after DONE.
- start or clr while busy: ignored.
- Multiplies are full 16x16 -> 32-bit unsigned; no truncation before the sum.
- S is not cleared by start; it accumulates across iterations until clr.

Test Plan:
- Reset value check: pulse rstn low mid-CALC (NWORDS=2) -> busy=0, done=0, low_err=0, s0_out=0, all s_rd_data reads return 0.
- Basic iteration (NWORDS=2): clr, then start with x_i=1, q_m=0xFFFD, Y={0x0003,0x0000}, M={0x0001,0x0001} -> S={0xFFFE,0x0000,0x0000}, low_err=0, done exactly 6 cycles after the start edge.
- Max-carry iteration: clr, x_i=q_m=0xFFFF, Y=M={0xFFFF,0xFFFF} -> S[0]=0xFFFE, S[1]=0xFFFD, S[2]=0x0001, low_err=1.
- Low-word error: clr, x_i=1, q_m=0, Y={0x0003,0}, M={0x0001,0x0001} -> low_err=1 after done; low_err stays 1 until the next start, then clears.
- Handshake/priority: clr and start asserted together in IDLE -> S cleared, busy stays 0. start pulsed again during RD -> ignored, single done pulse. mem_rd pattern is exactly 1,0,1,0 over the 4 cycles after start.
- Accumulation: run the basic iteration twice without clr (second run x_i=0, q_m=0) -> second result S={0x0000,0x0000,0x0000}. The first result shifted: S[0] old 0xFFFE goes to discarded word 0, low_err=1.
